program_sequencer: RTL and testbench
====================================

# program_sequencer

Parametrised instruction sequencer for the Aeolus control path. It replaces the free-running 2-bit phase counter and the derived divided clock with a single-clock design. A divider produces a clock-enable tick, and a four-phase FSM (FETCH/DECODE/EXECUTE/WRITEBACK) drives a program counter with skip, jump and halt. It sits between instruction memory and the instruction decoder, providing `ir` to the decoder and an `execStrobe` that qualifies register and ACC enables.

## Interface
- `PC_WIDTH`, default 4: program counter width; addresses wrap modulo 2^PC_WIDTH.
- `INSTR_WIDTH`, default 8: instruction word width.
- `DIV`, default 1: clk cycles per phase tick; legal range ≥1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; the sequencer advances continuously while high.
- `step`  in  1  single-step request. The rising edge is detected internally and is honoured only when `run`=0.
- `instrIn`  in  INSTR_WIDTH  memory data at address `pc`.
- `halt`  in  1  sampled on the EXECUTE tick.
- `jump`  in  1  sampled on the EXECUTE tick.
- `jumpAddr`  in  PC_WIDTH  jump target.
- `skip`  in  1  conditional skip (SF-qualified upstream), sampled on the EXECUTE tick.
- `pc`  out  PC_WIDTH  current instruction address.
- `ir`  out  INSTR_WIDTH  latched instruction.
- `phase`  out  4  one-hot {WRITEBACK,EXECUTE,DECODE,FETCH}; 0000 when halted.
- `tick`  out  1  phase-advance enable.
- `execStrobe`  out  1  `tick` & `phase[2]`.
- `halted`  out  1  high in HALTED.
- `wrapped`  out  1  one-clk pulse after `pc` wraps.

## Operation
- **Active:** `active` = !`halted` & (`run` | `stepPending`).
- **stepPending:** set on a `step` rising edge while `run`=0 and not halted. Cleared on the WRITEBACK→FETCH tick. A `step` edge while `run`=1 or while pending is ignored.
- **Divider:** counter 0..DIV-1, increments each clk while active. It holds and is cleared to 0 while inactive. `tick` = `active` & (`cnt`==DIV-1); with DIV=1, `tick`=`active`.
- **FSM:** advances only on `tick`.
  - FETCH: `ir` ← `instrIn`; go to DECODE.
  - DECODE: go to EXECUTE.
  - EXECUTE: compute `nextPc`; go to WRITEBACK, or to HALTED if `halt`.
  - WRITEBACK: `pc` ← `nextPc`; go to FETCH.
- **nextPc priority:** `halt` > `jump` > `skip` > increment.
  - `jump`: `nextPc` = `jumpAddr`.
  - `skip`: `nextPc` = `pc`+2.
  - otherwise: `nextPc` = `pc`+1.
  - All results are truncated to PC_WIDTH.
- **Wrap:** `wrapped` pulses for one clk, registered, after a WRITEBACK where the increment or skip carried out of PC_WIDTH. A jump never asserts `wrapped`, even to a lower address.
- **HALTED:**
  - `pc` keeps the address of the halting instruction; `ir` is held; `phase`=0000; `tick`=0.
  - Exit is by reset only. `run` and `step` are ignored.
- **Sampling:** `jump`, `jumpAddr`, `skip` and `halt` are sampled only on the EXECUTE tick and ignored at all other times.

## Timing
- **Reset values (async, reset low):** `pc`=0, `ir`=0, `phase`=0001, `tick`=0, `execStrobe`=0, `halted`=0, `wrapped`=0, divider=0, `stepPending`=0.
- **Reset release:** the first `tick` occurs DIV clks after `active` first goes high.
- **Reset mid-instruction:** the instruction is aborted with no WRITEBACK, and `pc` becomes 0.
- **Instruction period:** 4·DIV clks while running.
- **ir:** visible one clk after the FETCH tick edge.
- **pc:** updates on the WRITEBACK tick edge. `instrIn` must be valid by the next FETCH tick, i.e. memory latency ≤ DIV clks.
- **run deasserted mid-instruction:** the FSM freezes in place, the divider clears, and outputs are held. When `run` returns, the sequencer resumes from the same phase after a full DIV count.
- **Step completion:** a step runs one full instruction, ending in FETCH with `stepPending`=0. With DIV=1 a step takes 4 clks after the edge is detected.
- **Simultaneous events:**
  - A `step` edge in the same clk that `run` falls is ignored.
  - `halt` and `jump` in the same EXECUTE tick: halt wins and `pc` is unchanged.

## Test plan
- **Free run wrap:** DIV=1, PC_WIDTH=4, `run`=1, no controls. Expect `pc` to step 0,1,2,… every 4 clks, `execStrobe` to pulse once per 4 clks, and `pc` 15→0 with a single `wrapped` pulse after 64 clks.
- **Divided tick:** DIV=3. Expect `tick` every 3rd clk, `pc` to increment every 12 clks, and `ir` to equal the `instrIn` value present on the FETCH tick edge.
- **Skip, jump, priority:** skip at `pc`=14 → `pc`=0 with `wrapped`=1. Jump to 9 with `skip`=1 at `pc`=3 → `pc`=9, `wrapped`=0. Toggling `skip` outside EXECUTE has no effect.
- **Halt:** `halt`=1 on the EXECUTE tick at `pc`=5. Expect `halted`=1, `phase`=0000, `pc`=5 held; subsequent `run`/`step` do nothing; reset low → `pc`=0, `phase`=0001.
- **Single step:** `run`=0 with one `step` pulse → `pc` 0→1 after exactly 4 clks (DIV=1), then stop in FETCH. `step` held high for 20 clks → only one instruction executes.
- **Reset mid-instruction:** reset asserted asynchronously mid-cycle during EXECUTE with `jump`=1 → all outputs go immediately to their reset values, no jump occurs, and the sequence restarts from `pc`=0.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer: single-clock four-phase instruction sequencer.
// A clock-enable divider paces FETCH/DECODE/EXECUTE/WRITEBACK; the program
// counter advances by increment, skip (+2) or jump, and halts until reset.
module program_sequencer #(
  parameter int unsigned PC_WIDTH    = 4,
  parameter int unsigned INSTR_WIDTH = 8,
  parameter int unsigned DIV         = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   step,
  input  logic [INSTR_WIDTH-1:0] instrIn,
  input  logic                   halt,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jumpAddr,
  input  logic                   skip,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [3:0]             phase,
  output logic                   tick,
  output logic                   execStrobe,
  output logic                   halted,
  output logic                   wrapped
);

  localparam int unsigned      CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALTED
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                active;
  logic                step_d;
  logic                run_d;
  logic                step_rise;
  logic                step_pending;
  logic [PC_WIDTH-1:0] next_pc;
  logic                next_carry;
  logic [PC_WIDTH:0]   pc_inc;

  // Sequencer enable; reset is folded in so tick reads 0 while reset is held
  // even with run high and DIV=1.
  always_comb begin
    active     = reset & ~halted & (run | step_pending);
    tick       = active & (cnt == CNT_MAX);
    execStrobe = tick & phase[2];
    step_rise  = step & ~step_d;
  end

  // Sequential increment with carry-out for wrap detection (+2 on skip).
  always_comb begin
    pc_inc = {1'b0, pc} + (skip ? (PC_WIDTH+1)'(2) : (PC_WIDTH+1)'(1));
  end

  // Phase divider: counts while active, cleared whenever inactive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!active || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Single-step request: edge detect, ignored while running, in the clock
  // run falls, while already pending, or once halted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_d       <= 1'b0;
      run_d        <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      step_d <= step;
      run_d  <= run;
      if (tick && state == ST_WRITEBACK) begin
        step_pending <= 1'b0;
      end else if (step_rise && !run && !run_d && !halted) begin
        step_pending <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and one-hot phase decode.
  always_comb begin
    state_nxt = state;
    phase     = 4'b0000;
    halted    = 1'b0;
    case (state)
      ST_FETCH: begin
        phase = 4'b0001;
        if (tick) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        phase = 4'b0010;
        if (tick) state_nxt = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        phase = 4'b0100;
        if (tick) state_nxt = halt ? ST_HALTED : ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        phase = 4'b1000;
        if (tick) state_nxt = ST_FETCH;
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  // Datapath: instruction latch, next-pc resolution, pc commit, wrap pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      ir         <= '0;
      next_pc    <= '0;
      next_carry <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      wrapped <= 1'b0;
      if (tick) begin
        case (state)
          ST_FETCH: begin
            ir <= instrIn;
          end
          ST_EXECUTE: begin
            if (!halt) begin
              if (jump) begin
                next_pc    <= jumpAddr;
                next_carry <= 1'b0;
              end else begin
                next_pc    <= pc_inc[PC_WIDTH-1:0];
                next_carry <= pc_inc[PC_WIDTH];
              end
            end
          end
          ST_WRITEBACK: begin
            pc      <= next_pc;
            wrapped <= next_carry;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed bench for program_sequencer with a DIV=1
// instance (main behaviour) and a DIV=3 instance (divided tick).
module tb_program_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       step;
  logic       halt;
  logic       jump;
  logic       skip;
  logic [3:0] jumpAddr;
  logic [7:0] instrIn;
  logic [3:0] pc;
  logic [7:0] ir;
  logic [3:0] phase;
  logic       tick;
  logic       execStrobe;
  logic       halted;
  logic       wrapped;

  logic       run3;
  logic       tie0;
  logic [3:0] tie0_addr;
  logic [7:0] instr3;
  logic [3:0] pc3;
  logic [7:0] ir3;
  logic [3:0] phase3;
  logic       tick3;
  logic       es3;
  logic       halted3;
  logic       wrapped3;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic       h;
    logic       j;
    logic [3:0] ja;
    logic       s;
    logic       noise;
    logic [3:0] epc;
    logic       ew;
  } vec_t;

  // Instruction memory model: each word carries its own address.
  assign instrIn   = {4'hA, pc};
  assign tie0      = 1'b0;
  assign tie0_addr = 4'h0;

  program_sequencer #(.PC_WIDTH(4), .INSTR_WIDTH(8), .DIV(1)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .instrIn(instrIn),
    .halt(halt), .jump(jump), .jumpAddr(jumpAddr), .skip(skip),
    .pc(pc), .ir(ir), .phase(phase), .tick(tick), .execStrobe(execStrobe),
    .halted(halted), .wrapped(wrapped)
  );

  program_sequencer #(.PC_WIDTH(4), .INSTR_WIDTH(8), .DIV(3)) dut3 (
    .clk(clk), .reset(reset), .run(run3), .step(tie0), .instrIn(instr3),
    .halt(tie0), .jump(tie0), .jumpAddr(tie0_addr), .skip(tie0),
    .pc(pc3), .ir(ir3), .phase(phase3), .tick(tick3), .execStrobe(es3),
    .halted(halted3), .wrapped(wrapped3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clk_step(2);
    reset = 1'b1;
  endtask

  // One full instruction starting from FETCH; controls valid only in EXECUTE,
  // noise drives them high in the other phases.
  task automatic exec_instr(input logic h, input logic j, input logic [3:0] ja,
                            input logic s, input logic noise);
    halt = noise; jump = noise; jumpAddr = 4'h7; skip = noise;
    clk_step(2);
    halt = h; jump = j; jumpAddr = ja; skip = s;
    clk_step(1);
    halt = noise; jump = noise; jumpAddr = 4'h7; skip = noise;
    clk_step(1);
    halt = 1'b0; jump = 1'b0; skip = 1'b0;
  endtask

  vec_t vecs [10] = '{
    '{1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 4'd14, 1'b0},
    '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b1},
    '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd1,  1'b0},
    '{1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 4'd3,  1'b0},
    '{1'b0, 1'b1, 4'd9,  1'b1, 1'b0, 4'd9,  1'b0},
    '{1'b0, 1'b1, 4'd2,  1'b0, 1'b0, 4'd2,  1'b0},
    '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd4,  1'b0},
    '{1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 4'd15, 1'b0},
    '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd1,  1'b1},
    '{1'b0, 1'b1, 4'd5,  1'b0, 1'b0, 4'd5,  1'b0}
  };

  initial begin
    int es;
    int wc;
    int wc_total;
    int prev_pc;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0; run = 1'b1; step = 1'b0; halt = 1'b0; jump = 1'b0;
    skip = 1'b0; jumpAddr = 4'h0; run3 = 1'b1; instr3 = 8'h00;

    // Reset state, with run high during reset
    #1;
    check("rst_pc", 32'(pc), 0);
    check("rst_phase", 32'(phase), 1);
    check("rst_tick", 32'(tick), 0);
    clk_step(1);
    check("rst_ir", 32'(ir), 0);
    check("rst_tick_edge", 32'(tick), 0);
    check("rst_estrobe", 32'(execStrobe), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_wrapped", 32'(wrapped), 0);
    check("rst_tick3", 32'(tick3), 0);
    check("rst_pc3", 32'(pc3), 0);
    check("rst_phase3", 32'(phase3), 1);
    check("rst_misc3", 32'({es3, halted3, wrapped3}), 0);
    run3 = 1'b0;
    clk_step(1);
    reset = 1'b1;

    // Free run through a full wrap
    wc_total = 0;
    for (int k = 1; k <= 16; k++) begin
      es = 0;
      wc = 0;
      repeat (4) begin
        clk_step(1);
        es += int'(execStrobe);
        wc += int'(wrapped);
      end
      wc_total += wc;
      check($sformatf("fr_pc[%0d]", k), 32'(pc), k % 16);
      check($sformatf("fr_ir[%0d]", k), 32'(ir), 32'hA0 + k - 1);
      check($sformatf("fr_es[%0d]", k), es, 1);
      check($sformatf("fr_wrap[%0d]", k), 32'(wrapped), (k == 16) ? 1 : 0);
      check($sformatf("fr_phase[%0d]", k), 32'(phase), 1);
    end
    check("fr_wrap_total", wc_total, 1);
    clk_step(1);
    check("fr_wrap_oneclk", 32'(wrapped), 0);

    // Skip / jump / priority table
    do_reset();
    prev_pc = 0;
    for (int i = 0; i < 10; i++) begin
      exec_instr(vecs[i].h, vecs[i].j, vecs[i].ja, vecs[i].s, vecs[i].noise);
      check($sformatf("tbl_pc[%0d]", i), 32'(pc), 32'(vecs[i].epc));
      check($sformatf("tbl_wrap[%0d]", i), 32'(wrapped), 32'(vecs[i].ew));
      check($sformatf("tbl_ir[%0d]", i), 32'(ir), 32'hA0 + prev_pc);
      prev_pc = int'(vecs[i].epc);
    end

    // Halt with jump in the same EXECUTE: halt wins, pc held
    exec_instr(1'b1, 1'b1, 4'd12, 1'b0, 1'b0);
    check("halt_halted", 32'(halted), 1);
    check("halt_phase", 32'(phase), 0);
    check("halt_pc", 32'(pc), 5);
    check("halt_tick", 32'(tick), 0);
    check("halt_ir", 32'(ir), 32'hA5);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step = (i % 2 == 0);
      clk_step(1);
    end
    run = 1'b1;
    clk_step(4);
    step = 1'b0;
    check("halt_hold_pc", 32'(pc), 5);
    check("halt_hold_phase", 32'(phase), 0);
    check("halt_hold_halted", 32'(halted), 1);
    reset = 1'b0;
    #1;
    check("halt_rst_pc", 32'(pc), 0);
    check("halt_rst_phase", 32'(phase), 1);
    check("halt_rst_halted", 32'(halted), 0);

    // Asynchronous reset during EXECUTE with jump pending
    do_reset();
    exec_instr(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    exec_instr(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("mid_pc_before", 32'(pc), 2);
    clk_step(2);
    check("mid_in_exec", 32'(phase), 32'b0100);
    jump = 1'b1;
    jumpAddr = 4'd9;
    #3;
    reset = 1'b0;
    #1;
    check("mid_pc", 32'(pc), 0);
    check("mid_ir", 32'(ir), 0);
    check("mid_phase", 32'(phase), 1);
    check("mid_tick", 32'(tick), 0);
    check("mid_estrobe", 32'(execStrobe), 0);
    check("mid_halted_wrapped", 32'({halted, wrapped}), 0);
    jump = 1'b0;
    clk_step(1);
    reset = 1'b1;
    clk_step(1);
    check("mid_restart_ir", 32'(ir), 32'hA0);
    check("mid_restart_phase", 32'(phase), 32'b0010);
    clk_step(3);
    check("mid_restart_pc", 32'(pc), 1);

    // Single step with run low
    run = 1'b0;
    do_reset();
    clk_step(2);
    check("ss_idle_tick", 32'(tick), 0);
    step = 1'b1;
    clk_step(1);
    check("ss_active_tick", 32'(tick), 1);
    check("ss_fetch", 32'(phase), 1);
    clk_step(3);
    check("ss_pc_before", 32'(pc), 0);
    check("ss_wb", 32'(phase), 32'b1000);
    clk_step(1);
    check("ss_pc_after", 32'(pc), 1);
    check("ss_stop_fetch", 32'(phase), 1);
    clk_step(15);
    check("ss_held_pc", 32'(pc), 1);
    check("ss_held_phase", 32'(phase), 1);
    check("ss_held_tick", 32'(tick), 0);
    step = 1'b0;
    clk_step(1);
    step = 1'b1;
    clk_step(1);
    step = 1'b0;
    clk_step(3);
    check("ss2_pc_before", 32'(pc), 1);
    clk_step(1);
    check("ss2_pc_after", 32'(pc), 2);
    check("ss2_phase", 32'(phase), 1);

    // DIV=3 instance: tick every third clock, ir captured on FETCH tick edge
    run3 = 1'b1;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      instr3 = 8'(32'h40 + k);
      clk_step(1);
      check($sformatf("d3_tick[%0d]", k), 32'(tick3), ((k % 3) == 2) ? 1 : 0);
      if (k == 3)  check("d3_ir_first", 32'(ir3), 32'h43);
      if (k == 11) check("d3_pc_11", 32'(pc3), 0);
      if (k == 12) check("d3_pc_12", 32'(pc3), 1);
      if (k == 15) check("d3_ir_second", 32'(ir3), 32'h4F);
      if (k == 23) check("d3_pc_23", 32'(pc3), 1);
      if (k == 24) check("d3_pc_24", 32'(pc3), 2);
    end
    check("d3_dut1_idle", 32'(pc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
